// File: rtl/lun_router_pkg.sv
// lun_router_pkg
//   Shared definitions for the USB-MSC LUN router: FSM state encoding,
//   SCSI-mappable error codes and a helper for drive-select widths.
package lun_router_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BAD_LUN  = 3'd1;
    localparam logic [2:0] ERR_NO_MEDIA = 3'd2;
    localparam logic [2:0] ERR_WPROT    = 3'd3;
    localparam logic [2:0] ERR_RANGE    = 3'd4;
    localparam logic [2:0] ERR_BACKEND  = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd6;
    localparam logic [2:0] ERR_ILLEGAL  = 3'd7;

    // Select width for a drive type; never narrower than 1 bit.
    function automatic int sel_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lun_decode.sv
// lun_decode
//   Combinational LUN decoder. FDD LUNs occupy 0..NUM_FDD-1, HDD LUNs follow.
//   Ports:
//     lun                          LUN to decode
//     fdd_/hdd_present, _wprot     per-drive status vectors
//     fdd_/hdd_capacity            flattened capacities, drive i at [32i+:32]
//     valid                        LUN exists
//     is_fdd                       LUN maps to the FDD port
//     idx                          drive index within its type
//     present/wprot/capacity       status of the addressed drive (0 if invalid)
module lun_decode
    import lun_router_pkg::*;
#(
    parameter int NUM_FDD = 2,
    parameter int NUM_HDD = 2,
    parameter int LUN_W   = 3,
    parameter int IDX_W   = 1
) (
    input  logic [LUN_W-1:0]       lun,
    input  logic [NUM_FDD-1:0]     fdd_present,
    input  logic [NUM_FDD-1:0]     fdd_write_prot,
    input  logic [NUM_FDD*32-1:0]  fdd_capacity,
    input  logic [NUM_HDD-1:0]     hdd_present,
    input  logic [NUM_HDD-1:0]     hdd_write_prot,
    input  logic [NUM_HDD*32-1:0]  hdd_capacity,
    output logic                   valid,
    output logic                   is_fdd,
    output logic [IDX_W-1:0]       idx,
    output logic                   present,
    output logic                   wprot,
    output logic [31:0]            capacity
);

    int lun_i;

    // Loops compare against every drive so an out-of-range LUN never
    // indexes past the end of a status vector.
    always_comb begin
        lun_i    = int'(lun);
        valid    = (lun_i < NUM_FDD + NUM_HDD);
        is_fdd   = (lun_i < NUM_FDD);
        idx      = '0;
        present  = 1'b0;
        wprot    = 1'b0;
        capacity = '0;
        for (int i = 0; i < NUM_FDD; i++) begin
            if (lun_i == i) begin
                idx      = IDX_W'(i);
                present  = fdd_present[i];
                wprot    = fdd_write_prot[i];
                capacity = fdd_capacity[32*i +: 32];
            end
        end
        for (int j = 0; j < NUM_HDD; j++) begin
            if (lun_i == NUM_FDD + j) begin
                idx      = IDX_W'(j);
                present  = hdd_present[j];
                wprot    = hdd_write_prot[j];
                capacity = hdd_capacity[32*j +: 32];
            end
        end
    end

endmodule

// File: rtl/lun_drive_router.sv
// lun_drive_router
//   Routes SCSI block requests from the MSC engine onto the FDD or HDD HAL.
//   Each request is pre-checked (LUN, media, write-protect, LBA range),
//   issued with a 1-cycle strobe, then supervised for completion, abort and
//   watchdog timeout. All outputs are registered.
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     lun_select/read_req/write_req/lba/sector_count   request from SCSI engine
//     abort                        cancel the op in WAIT
//     ready/done/error/err_code    handshake and result
//     fdd_*/hdd_* outputs          select/lba/count/read/write toward the HALs
//     fdd_done/fdd_error, hdd_*    backend completion pulses
//     *_present/*_write_prot/*_capacity   per-drive status
//     active_lun, router_state     debug visibility
module lun_drive_router
    import lun_router_pkg::*;
#(
    parameter int NUM_FDD     = 2,
    parameter int NUM_HDD     = 2,
    parameter int LUN_W       = 3,
    parameter int TIMEOUT_CYC = 2**24,
    parameter int TO_W        = 25
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LUN_W-1:0]              lun_select,
    input  logic                          read_req,
    input  logic                          write_req,
    input  logic [31:0]                   lba,
    input  logic [15:0]                   sector_count,
    input  logic                          abort,
    output logic                          ready,
    output logic                          done,
    output logic                          error,
    output logic [2:0]                    err_code,
    output logic [sel_w(NUM_FDD)-1:0]     fdd_select,
    output logic [31:0]                   fdd_lba,
    output logic [15:0]                   fdd_count,
    output logic                          fdd_read,
    output logic                          fdd_write,
    input  logic                          fdd_done,
    input  logic                          fdd_error,
    output logic [sel_w(NUM_HDD)-1:0]     hdd_select,
    output logic [31:0]                   hdd_lba,
    output logic [15:0]                   hdd_count,
    output logic                          hdd_read,
    output logic                          hdd_write,
    input  logic                          hdd_done,
    input  logic                          hdd_error,
    input  logic [NUM_FDD-1:0]            fdd_present,
    input  logic [NUM_FDD-1:0]            fdd_write_prot,
    input  logic [NUM_HDD-1:0]            hdd_present,
    input  logic [NUM_HDD-1:0]            hdd_write_prot,
    input  logic [NUM_FDD*32-1:0]         fdd_capacity,
    input  logic [NUM_HDD*32-1:0]         hdd_capacity,
    output logic [LUN_W-1:0]              active_lun,
    output logic [2:0]                    router_state
);

    localparam int FSEL_W = sel_w(NUM_FDD);
    localparam int HSEL_W = sel_w(NUM_HDD);
    localparam int IDX_W  = (FSEL_W > HSEL_W) ? FSEL_W : HSEL_W;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [2:0]          err_code_q, err_code_d;
    logic [LUN_W-1:0]    lun_q, lun_d;
    logic [31:0]         lba_q, lba_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [TO_W-1:0]     wd_q, wd_d;
    logic [FSEL_W-1:0]   fdd_select_q, fdd_select_d;
    logic [31:0]         fdd_lba_q, fdd_lba_d;
    logic [15:0]         fdd_count_q, fdd_count_d;
    logic                fdd_read_q, fdd_read_d;
    logic                fdd_write_q, fdd_write_d;
    logic [HSEL_W-1:0]   hdd_select_q, hdd_select_d;
    logic [31:0]         hdd_lba_q, hdd_lba_d;
    logic [15:0]         hdd_count_q, hdd_count_d;
    logic                hdd_read_q, hdd_read_d;
    logic                hdd_write_q, hdd_write_d;

    logic                dec_valid, dec_is_fdd, dec_present, dec_wprot;
    logic [IDX_W-1:0]    dec_idx;
    logic [31:0]         dec_cap;
    logic [32:0]         end_lba;
    logic                be_done, be_error;

    // Decode from the latched LUN; it is stable from CHECK through WAIT.
    lun_decode #(
        .NUM_FDD (NUM_FDD),
        .NUM_HDD (NUM_HDD),
        .LUN_W   (LUN_W),
        .IDX_W   (IDX_W)
    ) u_decode (
        .lun            (lun_q),
        .fdd_present    (fdd_present),
        .fdd_write_prot (fdd_write_prot),
        .fdd_capacity   (fdd_capacity),
        .hdd_present    (hdd_present),
        .hdd_write_prot (hdd_write_prot),
        .hdd_capacity   (hdd_capacity),
        .valid          (dec_valid),
        .is_fdd         (dec_is_fdd),
        .idx            (dec_idx),
        .present        (dec_present),
        .wprot          (dec_wprot),
        .capacity       (dec_cap)
    );

    // 33-bit end address so lba near 2^32 cannot wrap into range.
    assign end_lba  = {1'b0, lba_q} + {17'b0, cnt_q};
    assign be_done  = dec_is_fdd ? fdd_done  : hdd_done;
    assign be_error = dec_is_fdd ? fdd_error : hdd_error;

    always_comb begin
        state_d      = state_q;
        err_code_d   = err_code_q;
        lun_d        = lun_q;
        lba_d        = lba_q;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        wd_d         = wd_q;
        fdd_select_d = fdd_select_q;
        fdd_lba_d    = fdd_lba_q;
        fdd_count_d  = fdd_count_q;
        hdd_select_d = hdd_select_q;
        hdd_lba_d    = hdd_lba_q;
        hdd_count_d  = hdd_count_q;
        fdd_read_d   = 1'b0;
        fdd_write_d  = 1'b0;
        hdd_read_d   = 1'b0;
        hdd_write_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (read_req || write_req) begin
                    state_d    = ST_CHECK;
                    lun_d      = lun_select;
                    lba_d      = lba;
                    cnt_d      = sector_count;
                    rd_d       = read_req;
                    wr_d       = write_req;
                    err_code_d = ERR_NONE;
                end
            end
            ST_CHECK: begin
                if (rd_q && wr_q) begin
                    state_d = ST_ERR; err_code_d = ERR_ILLEGAL;
                end else if (!dec_valid) begin
                    state_d = ST_ERR; err_code_d = ERR_BAD_LUN;
                end else if (!dec_present) begin
                    state_d = ST_ERR; err_code_d = ERR_NO_MEDIA;
                end else if (wr_q && dec_wprot) begin
                    state_d = ST_ERR; err_code_d = ERR_WPROT;
                end else if (end_lba > {1'b0, dec_cap}) begin
                    state_d = ST_ERR; err_code_d = ERR_RANGE;
                end else if (cnt_q == 16'd0) begin
                    state_d = ST_DONE;
                end else begin
                    // Strobe registers here so it is high for the ISSUE cycle.
                    state_d = ST_ISSUE;
                    wd_d    = '0;
                    if (dec_is_fdd) begin
                        fdd_select_d = dec_idx[FSEL_W-1:0];
                        fdd_lba_d    = lba_q;
                        fdd_count_d  = cnt_q;
                        fdd_read_d   = rd_q;
                        fdd_write_d  = wr_q;
                    end else begin
                        hdd_select_d = dec_idx[HSEL_W-1:0];
                        hdd_lba_d    = lba_q;
                        hdd_count_d  = cnt_q;
                        hdd_read_d   = rd_q;
                        hdd_write_d  = wr_q;
                    end
                end
            end
            ST_ISSUE: begin
                // Watchdog counts from the issue cycle, so the timeout
                // error lands TIMEOUT_CYC cycles after the strobe.
                state_d = ST_WAIT;
                wd_d    = wd_q + 1'b1;
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_ERR; err_code_d = ERR_ILLEGAL;
                end else if (be_error) begin
                    state_d = ST_ERR; err_code_d = ERR_BACKEND;
                end else if (be_done) begin
                    state_d = ST_DONE;
                end else if (wd_q == TO_LAST) begin
                    state_d = ST_ERR; err_code_d = ERR_TIMEOUT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
            lun_q        <= '0;
            lba_q        <= '0;
            cnt_q        <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            wd_q         <= '0;
            fdd_select_q <= '0;
            fdd_lba_q    <= '0;
            fdd_count_q  <= '0;
            fdd_read_q   <= 1'b0;
            fdd_write_q  <= 1'b0;
            hdd_select_q <= '0;
            hdd_lba_q    <= '0;
            hdd_count_q  <= '0;
            hdd_read_q   <= 1'b0;
            hdd_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
            lun_q        <= lun_d;
            lba_q        <= lba_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            wd_q         <= wd_d;
            fdd_select_q <= fdd_select_d;
            fdd_lba_q    <= fdd_lba_d;
            fdd_count_q  <= fdd_count_d;
            fdd_read_q   <= fdd_read_d;
            fdd_write_q  <= fdd_write_d;
            hdd_select_q <= hdd_select_d;
            hdd_lba_q    <= hdd_lba_d;
            hdd_count_q  <= hdd_count_d;
            hdd_read_q   <= hdd_read_d;
            hdd_write_q  <= hdd_write_d;
        end
    end

    assign ready        = ready_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_code_q;
    assign fdd_select   = fdd_select_q;
    assign fdd_lba      = fdd_lba_q;
    assign fdd_count    = fdd_count_q;
    assign fdd_read     = fdd_read_q;
    assign fdd_write    = fdd_write_q;
    assign hdd_select   = hdd_select_q;
    assign hdd_lba      = hdd_lba_q;
    assign hdd_count    = hdd_count_q;
    assign hdd_read     = hdd_read_q;
    assign hdd_write    = hdd_write_q;
    assign active_lun   = lun_q;
    assign router_state = state_q;

endmodule

// File: tb/tb_lun_drive_router.sv
// Directed bench for lun_drive_router: NUM_FDD=2, NUM_HDD=2, TIMEOUT_CYC=16.
// Drives: LUN0/1 = FDD (cap 2880), LUN2 = HDD0 (cap 1000), LUN3 = HDD1
// (cap 5000, write-protected).
module tb_lun_drive_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  lun_select;
    logic        read_req, write_req, abort;
    logic [31:0] lba;
    logic [15:0] sector_count;
    logic        ready, done, error;
    logic [2:0]  err_code;
    logic [0:0]  fdd_select, hdd_select;
    logic [31:0] fdd_lba, hdd_lba;
    logic [15:0] fdd_count, hdd_count;
    logic        fdd_read, fdd_write, hdd_read, hdd_write;
    logic        fdd_done, fdd_error, hdd_done, hdd_error;
    logic [1:0]  fdd_present, fdd_write_prot, hdd_present, hdd_write_prot;
    logic [63:0] fdd_capacity, hdd_capacity;
    logic [2:0]  active_lun, router_state;

    int total  = 0;
    int passed = 0;
    logic early_err;

    always #5 clk = ~clk;

    lun_drive_router #(
        .NUM_FDD(2), .NUM_HDD(2), .LUN_W(3), .TIMEOUT_CYC(16), .TO_W(5)
    ) dut (
        .clk(clk), .rst(rst), .lun_select(lun_select),
        .read_req(read_req), .write_req(write_req), .lba(lba),
        .sector_count(sector_count), .abort(abort),
        .ready(ready), .done(done), .error(error), .err_code(err_code),
        .fdd_select(fdd_select), .fdd_lba(fdd_lba), .fdd_count(fdd_count),
        .fdd_read(fdd_read), .fdd_write(fdd_write),
        .fdd_done(fdd_done), .fdd_error(fdd_error),
        .hdd_select(hdd_select), .hdd_lba(hdd_lba), .hdd_count(hdd_count),
        .hdd_read(hdd_read), .hdd_write(hdd_write),
        .hdd_done(hdd_done), .hdd_error(hdd_error),
        .fdd_present(fdd_present), .fdd_write_prot(fdd_write_prot),
        .hdd_present(hdd_present), .hdd_write_prot(hdd_write_prot),
        .fdd_capacity(fdd_capacity), .hdd_capacity(hdd_capacity),
        .active_lun(active_lun), .router_state(router_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present a request for one cycle; on return the DUT is in CHECK.
    task automatic do_req(input logic rd, input logic wr, input logic [2:0] l,
                          input logic [31:0] a, input logic [15:0] c);
        lun_select = l; read_req = rd; write_req = wr; lba = a; sector_count = c;
        tick();
        read_req = 1'b0; write_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; lun_select = '0; read_req = 0; write_req = 0; abort = 0;
        lba = '0; sector_count = '0;
        fdd_done = 0; fdd_error = 0; hdd_done = 0; hdd_error = 0;
        fdd_present = 2'b11; fdd_write_prot = 2'b00;
        hdd_present = 2'b11; hdd_write_prot = 2'b10;
        fdd_capacity = {32'd2880, 32'd2880};
        hdd_capacity = {32'd5000, 32'd1000};
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_state", router_state, 0);
        chk("rst_fdd_sel", fdd_select, 0);
        chk("rst_active_lun", active_lun, 0);

        // Stray backend pulse in IDLE is ignored
        fdd_done = 1; tick(); fdd_done = 0;
        chk("stray_state", router_state, 0);
        tick();
        chk("stray_done", done, 0);

        // FDD read LUN1, lba 0, count 18
        do_req(1, 0, 3'd1, 32'd0, 16'd18);
        chk("t1_ready_drop", ready, 0);
        chk("t1_state_check", router_state, 1);
        chk("t1_active_lun", active_lun, 1);
        tick();
        chk("t1_fdd_read", fdd_read, 1);
        chk("t1_fdd_sel", fdd_select, 1);
        chk("t1_fdd_count", fdd_count, 18);
        chk("t1_fdd_lba", fdd_lba, 0);
        chk("t1_hdd_read", hdd_read, 0);
        fdd_done = 1;
        tick();
        chk("t1_strobe_1cyc", fdd_read, 0);
        chk("t1_state_wait", router_state, 3);
        tick(); fdd_done = 0;
        chk("t1_done", done, 1);
        chk("t1_err_code", err_code, 0);
        tick();
        chk("t1_done_1cyc", done, 0);
        chk("t1_ready", ready, 1);

        // HDD write to write-protected LUN3
        do_req(0, 1, 3'd3, 32'd0, 16'd4);
        tick();
        chk("t2_error", error, 1);
        chk("t2_code", err_code, 3);
        chk("t2_no_hdd_write", hdd_write, 0);
        tick();
        chk("t2_err_1cyc", error, 0);
        chk("t2_code_held", err_code, 3);

        // Range: LUN2 cap 1000, lba 990 count 10 -> issued
        do_req(1, 0, 3'd2, 32'd990, 16'd10);
        tick();
        chk("t3_hdd_read", hdd_read, 1);
        chk("t3_hdd_sel", hdd_select, 0);
        chk("t3_hdd_lba", hdd_lba, 990);
        chk("t3_fdd_lba_kept", fdd_lba, 0);
        chk("t3_fdd_count_kept", fdd_count, 18);
        hdd_done = 1;
        tick(); tick(); hdd_done = 0;
        chk("t3_done", done, 1);
        tick();

        // lba 991 count 10 -> range error
        do_req(1, 0, 3'd2, 32'd991, 16'd10);
        tick();
        chk("t4_error", error, 1);
        chk("t4_code", err_code, 4);
        tick();

        // lba FFFFFFFF count 2 -> range error, no wrap
        do_req(1, 0, 3'd2, 32'hFFFF_FFFF, 16'd2);
        tick();
        chk("t5_code", err_code, 4);
        chk("t5_no_strobe", hdd_read, 0);
        tick();

        // Bad LUN 5
        do_req(1, 0, 3'd5, 32'd0, 16'd1);
        tick();
        chk("t6_code", err_code, 1);
        tick();

        // count 0 on valid LUN -> done, no strobe
        do_req(1, 0, 3'd0, 32'd0, 16'd0);
        tick();
        chk("t7_done", done, 1);
        chk("t7_no_strobe", fdd_read, 0);
        chk("t7_code", err_code, 0);
        tick();

        // Backend done and error together -> error wins
        do_req(1, 0, 3'd0, 32'd5, 16'd1);
        tick();
        fdd_done = 1; fdd_error = 1;
        tick(); tick();
        fdd_done = 0; fdd_error = 0;
        chk("t8_error", error, 1);
        chk("t8_done", done, 0);
        chk("t8_code", err_code, 5);
        tick();

        // Timeout: error exactly 16 cycles after the issue cycle
        do_req(1, 0, 3'd0, 32'd7, 16'd1);
        tick();
        chk("t9_issue", fdd_read, 1);
        early_err = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (error) early_err = 1;
        end
        chk("t9_no_early_err", early_err, 0);
        tick();
        chk("t9_error", error, 1);
        chk("t9_code", err_code, 6);
        tick();

        // Abort in WAIT beats a same-cycle backend done
        do_req(1, 0, 3'd1, 32'd0, 16'd1);
        tick(); tick();
        abort = 1; fdd_done = 1;
        tick();
        abort = 0; fdd_done = 0;
        chk("t10_error", error, 1);
        chk("t10_done", done, 0);
        chk("t10_code", err_code, 7);
        tick();
        chk("t10_ready", ready, 1);

        // Both request bits -> illegal
        do_req(1, 1, 3'd0, 32'd0, 16'd1);
        tick();
        chk("t11_code", err_code, 7);
        tick();

        // No media on LUN1
        fdd_present = 2'b01;
        do_req(1, 0, 3'd1, 32'd0, 16'd1);
        tick();
        chk("t12_code", err_code, 2);
        tick();
        fdd_present = 2'b11;

        // Reset during WAIT
        do_req(1, 0, 3'd1, 32'd3, 16'd1);
        tick(); tick();
        chk("t13_in_wait", router_state, 3);
        rst = 1;
        tick();
        rst = 0;
        chk("t13_state", router_state, 0);
        chk("t13_ready", ready, 1);
        chk("t13_fdd_sel", fdd_select, 0);
        fdd_done = 1;
        tick();
        fdd_done = 0;
        chk("t13_no_done", done, 0);
        chk("t13_no_error", error, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
